liteic_arbiter: RTL and testbench
=================================

Name: liteic_arbiter

Overview:
- Parametrised, registered request arbiter for the liteic interconnect; successor to the static priority encoder.
- Selects one of N_REQ requesters in either fixed-priority or round-robin mode.
- Locks the grant until the downstream slave signals completion, then re-arbitrates. Back-to-back grants are supported.
- Outputs a one-hot grant plus its binary index for mux select at the interconnect crossbar.

Parameters:
N_REQ, 20, number of requesters (legal range 2..32)
IDX_W, $clog2(N_REQ), width of binary grant index
RR_MODE, 1, 0 = fixed priority (highest index wins), 1 = round robin

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
req_i  input  N_REQ  per-requester request, level sensitive
done_i  input  1  single-cycle pulse from slave: current transaction complete
grant_o  output  N_REQ  registered one-hot grant, all zero when idle
grant_idx_o  output  IDX_W  binary index of granted requester, zero when idle
grant_vld_o  output  1  high while a grant is held (equals |grant_o)

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; grant_o=0; grant_idx_o=0; grant_vld_o=0; rr pointer=0. Release is synchronous to clk via the normal flop path; no outputs change until the first edge after release.
- States: IDLE and BUSY.
- IDLE, req_i != 0 at edge t:
  - Winner is selected combinationally.
  - At t+1: grant_o = one-hot winner, grant_idx_o = index, grant_vld_o = 1, state BUSY. Latency is 1 cycle.
- IDLE, req_i == 0: stay IDLE with outputs 0.
- IDLE, done_i: ignored.
- BUSY, done_i low: grant held unchanged, even if the granted requester drops req_i or a higher-priority request arrives. No preemption.
- BUSY, done_i high at edge t:
  - If req_i != 0 in the same cycle, a new winner is registered at t+1 and the state stays BUSY. This gives back-to-back grants with zero idle cycles.
  - The requester just granted competes normally under the active mode.
  - Otherwise, at t+1 grant_o = 0, grant_idx_o = 0, grant_vld_o = 0, state IDLE.
- Fixed priority (RR_MODE=0): highest set bit of req_i wins. rr pointer is unused.
- Round robin (RR_MODE=1):
  - Search starts at index ptr and proceeds upward; the first set bit wins.
  - The search wraps modulo N_REQ, from N_REQ-1 to 0.
  - On every registered grant to index k: ptr <= (k == N_REQ-1) ? 0 : k+1.
  - ptr is unchanged when no grant is issued.
- grant_idx_o is derived from the registered one-hot vector by OR-reduction masks: bit j = OR of grant_o[i] over all i whose bit j is set.
- Invariants, checked every cycle:
  - grant_o is zero or one-hot.
  - grant_vld_o == |grant_o.
  - No grant changes in BUSY without done_i.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously); the locked transaction is abandoned and the pointer returns to 0.
- Bits of req_i beyond N_REQ do not exist. X on req_i while BUSY and done_i low must not affect outputs.

Test Plan:
- Reset: rstn=0 with req_i=20'hFFFFF -> grant_o=0, grant_idx_o=0, grant_vld_o=0. Release rstn -> next edge grant_idx_o=19 with RR_MODE=0, or 0 with RR_MODE=1.
- Fixed priority: RR_MODE=0, req_i=20'h00812 -> 1 cycle later grant_o=20'h00800, grant_idx_o=11. Raise req_i[19] without done_i -> grant stays 11. Pulse done_i -> grant_idx_o=19.
- Round-robin fairness: RR_MODE=1, req_i=20'hFFFFF held, done_i pulsed every 2nd cycle -> grant_idx_o sequence 0,1,2,...,19,0 with no index skipped or repeated.
- Wrap-around: RR_MODE=1, after a grant to 18, req_i bits {3,18} set, done_i -> next grant 3. Then done_i with only bit 3 set -> grant 3 again.
- Back-to-back: done_i and req_i=20'h00020 both high in the same cycle -> next edge grant_idx_o=5, grant_vld_o never deasserts. Then done_i with req_i=0 -> grant_vld_o=0 one cycle later.
- Mid-op reset: BUSY with grant_idx_o=7, assert rstn=0 between edges -> outputs clear without waiting for clk. After release, RR search starts from ptr=0.

Source files
------------

// File: rtl/liteic_arbiter.sv
// liteic_arbiter
//   Registered request arbiter for the liteic interconnect. Picks one of
//   N_REQ requesters and holds that grant until the slave pulses done_i.
//   When done_i arrives with requests pending, the next grant is issued on
//   the following edge, so there are no idle cycles between grants.
//   RR_MODE=0 gives fixed priority (highest index wins). RR_MODE=1 gives
//   round robin starting from a rotating pointer.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rstn         asynchronous active-low reset
//   req_i        per-requester request, level sensitive
//   done_i       one-cycle pulse from the slave: transaction complete
//   grant_o      registered one-hot grant, all zero when idle
//   grant_idx_o  binary index of the granted requester, zero when idle
//   grant_vld_o  high while a grant is held
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant held; any request is granted on the next edge
// BUSY  | grant locked; re-arbitrate only on done_i

module liteic_arbiter #(
  parameter int unsigned N_REQ   = 20,
  parameter int unsigned IDX_W   = $clog2(N_REQ),
  parameter int unsigned RR_MODE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;

  logic             w_win_vld;
  logic [IDX_W-1:0] w_win_idx;
  logic [N_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0] w_ptr_adv;
  logic [IDX_W-1:0] w_grant_idx;

  // Bit j of this mask is set for every requester whose index has bit j set.
  function automatic logic [N_REQ-1:0] idx_mask(input int bitpos);
    logic [N_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < N_REQ; i++) begin
      m[i] = (((i >> bitpos) & 1) == 1);
    end
    return m;
  endfunction

  assign w_win_vld = |req_i;

  generate
    if (RR_MODE == 0) begin : g_fixed
      // Ascending scan, last hit is kept: the highest set bit wins.
      always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
          if (req_i[IDX_W'(i)]) begin
            w_win_idx = IDX_W'(i);
          end
        end
      end
    end else begin : g_rr
      // Scan N_REQ positions starting at the pointer, wrapping past the top.
      always_comb begin
        logic found;
        int   pos;
        found     = 1'b0;
        pos       = 0;
        w_win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
          pos = int'(r_ptr) + k;
          if (pos >= int'(N_REQ)) begin
            pos = pos - int'(N_REQ);
          end
          if (!found && req_i[IDX_W'(pos)]) begin
            found     = 1'b1;
            w_win_idx = IDX_W'(pos);
          end
        end
      end
    end
  endgenerate

  assign w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_ptr_adv    = (w_win_idx == IDX_W'(N_REQ-1)) ? '0 : w_win_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win_onehot;
          if (RR_MODE != 0) w_ptr_nxt = w_ptr_adv;
        end
      end
      ST_BUSY: begin
        // req_i is only looked at on done_i, so the lock cannot be disturbed.
        if (done_i) begin
          if (w_win_vld) begin
            w_grant_nxt = w_win_onehot;
            if (RR_MODE != 0) w_ptr_nxt = w_ptr_adv;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Index is encoded from the registered one-hot, so it can never disagree
  // with grant_o and needs no flops of its own.
  generate
    for (genvar j = 0; j < IDX_W; j++) begin : g_idx
      assign w_grant_idx[j] = |(r_grant & idx_mask(j));
    end
  endgenerate

  assign grant_o     = r_grant;
  assign grant_idx_o = w_grant_idx;
  assign grant_vld_o = |r_grant;

endmodule

// File: tb/tb_liteic_arbiter.sv
// Testbench for liteic_arbiter. Two instances share stimulus: one fixed
// priority, one round robin. A reference model pushes the expected outputs
// for each edge into per-instance queues; a monitor pops and compares after
// every rising edge.

module tb_liteic_arbiter;

  localparam int N = 20;
  localparam int W = 5;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] idx;
    logic [N-1:0] grant;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic [N-1:0] req_i;
  logic         done_i;

  logic [N-1:0] fp_grant, rr_grant;
  logic [W-1:0] fp_idx, rr_idx;
  logic         fp_vld, rr_vld;

  int checks   = 0;
  int failures = 0;

  exp_t q_fp[$];
  exp_t q_rr[$];

  // model state, index 0 = fixed priority, 1 = round robin
  bit m_busy[2];
  int m_idx[2];
  int m_ptr[2];

  liteic_arbiter #(.N_REQ(N), .RR_MODE(0)) dut_fp (
    .clk(clk), .rstn(rstn), .req_i(req_i), .done_i(done_i),
    .grant_o(fp_grant), .grant_idx_o(fp_idx), .grant_vld_o(fp_vld)
  );

  liteic_arbiter #(.N_REQ(N), .RR_MODE(1)) dut_rr (
    .clk(clk), .rstn(rstn), .req_i(req_i), .done_i(done_i),
    .grant_o(rr_grant), .grant_idx_o(rr_idx), .grant_vld_o(rr_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [N-1:0] req, input int ptr, input bit rr);
    int p;
    if (!rr) begin
      for (int i = N-1; i >= 0; i--) begin
        if (req[i]) return i;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        p = (ptr + k) % N;
        if (req[p]) return p;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0;
      m_idx[m]  = 0;
      m_ptr[m]  = 0;
    end
  endtask

  function automatic exp_t model_exp(input int m);
    exp_t e;
    e.vld   = m_busy[m];
    e.idx   = m_busy[m] ? W'(m_idx[m]) : '0;
    e.grant = m_busy[m] ? (N'(1) << m_idx[m]) : '0;
    return e;
  endfunction

  // Drive inputs for the coming edge, advance the model, queue expectations,
  // then move on to the next falling edge.
  task automatic step(input logic [N-1:0] req, input logic done);
    int w;
    req_i  = req;
    done_i = done;
    for (int m = 0; m < 2; m++) begin
      if (!m_busy[m] || done) begin
        w = pick(req, m_ptr[m], m == 1);
        if (w >= 0) begin
          m_busy[m] = 1'b1;
          m_idx[m]  = w;
          m_ptr[m]  = (w + 1) % N;
        end else begin
          m_busy[m] = 1'b0;
          m_idx[m]  = 0;
        end
      end
    end
    q_fp.push_back(model_exp(0));
    q_rr.push_back(model_exp(1));
    @(negedge clk);
  endtask

  task automatic compare(input string name, input exp_t e,
                         input logic [N-1:0] g, input logic [W-1:0] idx,
                         input logic vld);
    checks++;
    if (g !== e.grant || idx !== e.idx || vld !== e.vld) begin
      failures++;
      $display("FAIL %s t=%0t: got grant=%h idx=%0d vld=%b, want grant=%h idx=%0d vld=%b",
               name, $time, g, idx, vld, e.grant, e.idx, e.vld);
    end
    checks++;
    if (!$onehot0(g) || vld !== (|g)) begin
      failures++;
      $display("FAIL %s_invariant t=%0t: grant=%h vld=%b", name, $time, g, vld);
    end
  endtask

  task automatic check_idle(input string name);
    exp_t z;
    z = '0;
    compare({name, "_fp"}, z, fp_grant, fp_idx, fp_vld);
    compare({name, "_rr"}, z, rr_grant, rr_idx, rr_vld);
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (q_fp.size() == 0 || q_rr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard t=%0t: no expectation queued", $time);
        end else begin
          compare("fp", q_fp.pop_front(), fp_grant, fp_idx, fp_vld);
          compare("rr", q_rr.pop_front(), rr_grant, rr_idx, rr_vld);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         d;
    rstn   = 1'b1;
    req_i  = 20'hFFFFF;
    done_i = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    #2 check_idle("reset");

    // release with all requests pending: fp -> 19, rr -> 0
    @(negedge clk);
    rstn = 1'b1;
    step(20'hFFFFF, 1'b0);
    step(20'h00000, 1'b1);

    // fixed priority and no preemption
    step(20'h00812, 1'b0);
    step(20'h80812, 1'b0);
    step(20'h80812, 1'b0);
    step(20'h80812, 1'b1);
    step(20'h00000, 1'b1);

    // round-robin fairness: done every 2nd cycle
    step(20'hFFFFF, 1'b0);
    for (int i = 0; i < 21; i++) begin
      step(20'hFFFFF, 1'b1);
      step(20'hFFFFF, 1'b0);
    end
    step(20'h00000, 1'b1);

    // wrap-around after a grant to 18
    step(20'h40000, 1'b0);
    step(20'h40008, 1'b1);
    step(20'h00008, 1'b1);
    step(20'h00008, 1'b0);

    // back-to-back then drop to idle
    step(20'h00020, 1'b1);
    step(20'h00000, 1'b0);
    step(20'h00000, 1'b1);
    step(20'h00000, 1'b0);

    // done_i while idle is ignored
    step(20'h00000, 1'b1);

    // mid-transaction reset clears outputs without a clock edge
    step(20'h00080, 1'b0);
    #2 rstn = 1'b0;
    #1 check_idle("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(20'h00208, 1'b0);
    step(20'h00000, 1'b1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N-1);
        2: r = N'($urandom() & $urandom() & $urandom());
        default: r = N'($urandom());
      endcase
      d = ($urandom_range(0, 2) == 0);
      if (m_busy[0] && !d && $urandom_range(0, 7) == 0) r = 'x;
      step(r, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
